// File: rtl/freq_div_meter.sv
// freq_div_meter: measures period and high time of CLK_sig in CLK_in cycles,
// reports each full period with a VALID pulse, and flags LOCK once the period
// repeats LOCK_N times in a row. OVF flags a missing rising edge.
module freq_div_meter #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 4
) (
    input  logic             CLK_in,
    input  logic             RST,
    input  logic             SYNC,
    input  logic             CLK_sig,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH,
    output logic             VALID,
    output logic             LOCK,
    output logic             OVF
);

    localparam int MCNT_W = (LOCK_N > 2) ? $clog2(LOCK_N) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [MCNT_W-1:0] MCNT_MAX = MCNT_W'(LOCK_N - 1);

    typedef enum logic [1:0] {
        ST_SEEK  = 2'd0,
        ST_MEAS  = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic              valid_q, valid_d;
    logic              lock_q, lock_d;
    logic              ovf_q, ovf_d;
    // Set by the first report after reset; PERIOD is meaningful from then on,
    // so later matches compare against it even across SEEK re-arms.
    logic              have_prev_q, have_prev_d;

    logic              rise;
    logic [MCNT_W-1:0] mcnt_new;

    assign rise = s1_q & ~s2_q;

    // Next-state logic: edge detect, window counters, report/lock/overflow control
    always_comb begin
        state_d     = state_q;
        s1_d        = CLK_sig;
        s2_d        = s1_q;
        period_d    = period_q;
        high_d      = high_q;
        mcnt_d      = mcnt_q;
        lock_d      = lock_q;
        ovf_d       = ovf_q;
        have_prev_d = have_prev_q;
        valid_d     = 1'b0;
        mcnt_new    = '0;

        // Window counters restart on the rise cycle so they cover R .. R-1
        if (rise) begin
            cnt_d  = CNT_W'(1);
            hcnt_d = CNT_W'(1);
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            hcnt_d = hcnt_q + CNT_W'(s1_q);
        end

        if (!SYNC) begin
            // Clear measurement; the edge detector keeps sampling and the
            // last report is retained.
            state_d = ST_SEEK;
            cnt_d   = '0;
            hcnt_d  = '0;
            mcnt_d  = '0;
            lock_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_SEEK: begin
                    // First rise only opens a window; nothing to report yet
                    if (rise) begin
                        state_d = ST_MEAS;
                    end
                end
                ST_MEAS, ST_TRACK: begin
                    if (rise) begin
                        period_d    = cnt_q;
                        high_d      = hcnt_q;
                        valid_d     = 1'b1;
                        ovf_d       = 1'b0;
                        have_prev_d = 1'b1;
                        state_d     = ST_TRACK;
                        if (have_prev_q && (cnt_q == period_q)) begin
                            mcnt_new = (mcnt_q == MCNT_MAX) ? mcnt_q
                                                            : mcnt_q + MCNT_W'(1);
                        end else begin
                            mcnt_new = '0;
                        end
                        mcnt_d = mcnt_new;
                        lock_d = (mcnt_new == MCNT_MAX);
                    end else if (cnt_q == CNT_MAX) begin
                        // Counter would exceed its range: no edge in time
                        ovf_d   = 1'b1;
                        lock_d  = 1'b0;
                        mcnt_d  = '0;
                        state_d = ST_SEEK;
                    end
                end
                default: begin
                    state_d = ST_SEEK;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK_in or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_SEEK;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            mcnt_q      <= '0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            lock_q      <= 1'b0;
            ovf_q       <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            mcnt_q      <= mcnt_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            lock_q      <= lock_d;
            ovf_q       <= ovf_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign PERIOD = period_q;
    assign HIGH   = high_q;
    assign VALID  = valid_q;
    assign LOCK   = lock_q;
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_freq_div_meter.sv
// Directed bench for freq_div_meter: default instance (LOCK_N=4) plus a
// LOCK_N=2 instance sharing the same stimulus.
module tb_freq_div_meter;

    localparam int CNT_W = 8;

    logic             CLK_in;
    logic             RST;
    logic             SYNC;
    logic             CLK_sig;
    logic [CNT_W-1:0] PERIOD, PERIOD2;
    logic [CNT_W-1:0] HIGH, HIGH2;
    logic             VALID, VALID2;
    logic             LOCK, LOCK2;
    logic             OVF, OVF2;

    int vec_cnt = 0;
    int err_cnt = 0;

    freq_div_meter #(.CNT_W(CNT_W), .LOCK_N(4)) u_dut (
        .CLK_in (CLK_in),
        .RST    (RST),
        .SYNC   (SYNC),
        .CLK_sig(CLK_sig),
        .PERIOD (PERIOD),
        .HIGH   (HIGH),
        .VALID  (VALID),
        .LOCK   (LOCK),
        .OVF    (OVF)
    );

    freq_div_meter #(.CNT_W(CNT_W), .LOCK_N(2)) u_dut2 (
        .CLK_in (CLK_in),
        .RST    (RST),
        .SYNC   (SYNC),
        .CLK_sig(CLK_sig),
        .PERIOD (PERIOD2),
        .HIGH   (HIGH2),
        .VALID  (VALID2),
        .LOCK   (LOCK2),
        .OVF    (OVF2)
    );

    initial begin
        CLK_in = 1'b0;
        forever #5 CLK_in = ~CLK_in;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        vec_cnt++;
        if (obs != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive CLK_sig for the next rising edge, return at the following negedge
    task automatic step(input logic v);
        CLK_sig = v;
        @(negedge CLK_in);
    endtask

    // One CLK_sig period (h high, l low). The report, if any, is visible
    // after the second step of the period (2 edges after the sampled rise).
    // exp_lk / exp_lk2 < 0 means not checked.
    task automatic run_period(input string tag, input int h, input int l,
                              input bit exp_v, input int exp_p, input int exp_h,
                              input int exp_lk, input int exp_lk2);
        logic         v_s, lk_s, ovf_s;
        logic [CNT_W-1:0] p_s, h_s;
        v_s = 1'b0; lk_s = 1'b0; ovf_s = 1'b0; p_s = '0; h_s = '0;
        for (int i = 0; i < h + l; i++) begin
            step(i < h);
            if (i == 1) begin
                v_s = VALID; lk_s = LOCK; ovf_s = OVF; p_s = PERIOD; h_s = HIGH;
                check_val({tag, "/valid"}, int'(VALID), int'(exp_v));
                if (exp_v) begin
                    check_val({tag, "/period"}, int'(PERIOD), exp_p);
                    check_val({tag, "/high"}, int'(HIGH), exp_h);
                    check_val({tag, "/ovf"}, int'(OVF), 0);
                    if (exp_lk >= 0)  check_val({tag, "/lock"}, int'(LOCK), exp_lk);
                    if (exp_lk2 >= 0) check_val({tag, "/lock2"}, int'(LOCK2), exp_lk2);
                end
            end else begin
                check_val({tag, "/valid_idle"}, int'(VALID), 0);
            end
        end
        $display("%s: h=%0d l=%0d VALID=%0b PERIOD=%0d HIGH=%0d LOCK=%0b OVF=%0b",
                 tag, h, l, v_s, p_s, h_s, lk_s, ovf_s);
    endtask

    initial begin
        RST = 1'b0; SYNC = 1'b1; CLK_sig = 1'b0;
        step(0); step(0);
        check_val("rst/period", int'(PERIOD), 0);
        check_val("rst/high", int'(HIGH), 0);
        check_val("rst/valid", int'(VALID), 0);
        check_val("rst/lock", int'(LOCK), 0);
        check_val("rst/ovf", int'(OVF), 0);
        check_val("rst/lock2", int'(LOCK2), 0);
        $display("reset: PERIOD=%0d HIGH=%0d VALID=%0b LOCK=%0b OVF=%0b",
                 PERIOD, HIGH, VALID, LOCK, OVF);
        RST = 1'b1;
        step(0); step(0);

        // 3 high / 2 low: arm, then reports of 5/3, lock at 4th report
        run_period("p5_1", 3, 2, 0, 0, 0, -1, -1);
        run_period("p5_2", 3, 2, 1, 5, 3, 0, 0);
        run_period("p5_3", 3, 2, 1, 5, 3, 0, 1);
        run_period("p5_4", 3, 2, 1, 5, 3, 0, 1);
        run_period("p5_5", 3, 2, 1, 5, 3, 1, 1);
        run_period("p5_6", 3, 2, 1, 5, 3, 1, 1);

        // Switch to period 6: lock drops on first 6 report, returns on 4th
        run_period("p6_1", 3, 3, 1, 5, 3, 1, 1);
        run_period("p6_2", 3, 3, 1, 6, 3, 0, 0);
        run_period("p6_3", 3, 3, 1, 6, 3, 0, 1);
        run_period("p6_4", 3, 3, 1, 6, 3, 0, 1);
        run_period("p6_5", 3, 3, 1, 6, 3, 1, 1);

        // Back to period 5 and relock
        run_period("r5_1", 3, 2, 1, 6, 3, 1, 1);
        run_period("r5_2", 3, 2, 1, 5, 3, 0, 0);
        run_period("r5_3", 3, 2, 1, 5, 3, 0, 1);
        run_period("r5_4", 3, 2, 1, 5, 3, 0, 1);
        run_period("r5_5", 3, 2, 1, 5, 3, 1, 1);

        // Hold low 300 cycles: OVF exactly 255 edges after the last rise report edge
        for (int j = 0; j < 300; j++) begin
            step(0);
            if (j == 250) check_val("ovf/before", int'(OVF), 0);
            if (j == 251) begin
                check_val("ovf/set", int'(OVF), 1);
                check_val("ovf/lock", int'(LOCK), 0);
                check_val("ovf/lock2", int'(LOCK2), 0);
                check_val("ovf/period", int'(PERIOD), 5);
                check_val("ovf/high", int'(HIGH), 3);
                $display("overflow: j=%0d OVF=%0b LOCK=%0b PERIOD=%0d", j, OVF, LOCK, PERIOD);
            end
        end
        check_val("ovf/sticky", int'(OVF), 1);

        // Resume: first rise only re-arms, second reports and clears OVF
        run_period("s5_1", 3, 2, 0, 0, 0, -1, -1);
        check_val("s5_1/ovf_held", int'(OVF), 1);
        run_period("s5_2", 3, 2, 1, 5, 3, 0, -1);
        run_period("s5_3", 3, 2, 1, 5, 3, -1, -1);
        run_period("s5_4", 3, 2, 1, 5, 3, -1, -1);
        run_period("s5_5", 3, 2, 1, 5, 3, 1, 1);
        run_period("s5_6", 3, 2, 1, 5, 3, 1, 1);

        // SYNC low 3 cycles while locked
        SYNC = 1'b0;
        step(0); step(0); step(0);
        SYNC = 1'b1;
        check_val("sync/lock", int'(LOCK), 0);
        check_val("sync/ovf", int'(OVF), 0);
        check_val("sync/valid", int'(VALID), 0);
        check_val("sync/period", int'(PERIOD), 5);
        check_val("sync/high", int'(HIGH), 3);
        $display("sync: LOCK=%0b OVF=%0b VALID=%0b PERIOD=%0d", LOCK, OVF, VALID, PERIOD);
        run_period("t5_1", 3, 2, 0, 0, 0, -1, -1);
        run_period("t5_2", 3, 2, 1, 5, 3, 0, -1);

        // Divide-by-2
        run_period("d2_1", 1, 1, 1, 5, 3, -1, -1);
        run_period("d2_2", 1, 1, 1, 2, 1, 0, 0);
        run_period("d2_3", 1, 1, 1, 2, 1, 0, 1);
        run_period("d2_4", 1, 1, 1, 2, 1, 0, 1);
        run_period("d2_5", 1, 1, 1, 2, 1, 1, 1);

        // Divide-by-23, 11 high / 12 low
        run_period("d23_1", 11, 12, 1, 2, 1, 1, 1);
        run_period("d23_2", 11, 12, 1, 23, 11, 0, 0);
        run_period("d23_3", 11, 12, 1, 23, 11, 0, 1);
        run_period("d23_4", 11, 12, 1, 23, 11, 0, 1);
        run_period("d23_5", 11, 12, 1, 23, 11, 1, 1);

        // Asynchronous reset mid-period
        step(1); step(1); step(1); step(1); step(1);
        CLK_sig = 1'b0;
        RST = 1'b0;
        #2;
        check_val("arst/period", int'(PERIOD), 0);
        check_val("arst/high", int'(HIGH), 0);
        check_val("arst/valid", int'(VALID), 0);
        check_val("arst/lock", int'(LOCK), 0);
        check_val("arst/ovf", int'(OVF), 0);
        check_val("arst/lock2", int'(LOCK2), 0);
        $display("async reset: PERIOD=%0d HIGH=%0d LOCK=%0b OVF=%0b", PERIOD, HIGH, LOCK, OVF);
        step(0);
        RST = 1'b1;
        step(0); step(0);
        run_period("f5_1", 3, 2, 0, 0, 0, -1, -1);
        run_period("f5_2", 3, 2, 1, 5, 3, 0, 0);
        run_period("f5_3", 3, 2, 1, 5, 3, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
